// File: rtl/hex_mul_pkg.sv
// Shared definitions for the digit-serial hex multiplier.
// Holds the digit width, the sequencing state type and a product-width helper.
package hex_mul_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } hex_mul_state_t;

    // Full product width for an operand of 'digits' hex digits.
    function automatic int unsigned prod_width(input int unsigned digits);
        return 2 * DIGIT_W * digits;
    endfunction

endpackage

// File: rtl/hex_mul_seq_if.sv
// Operand/result handshake bundle for hex_mul_seq.
//   in_valid/in_ready  : operand acceptance (a, b)
//   out_valid/out_ready: product delivery (product)
//   busy               : block is not idle
// master = operand producer / product consumer, slave = multiplier.
interface hex_mul_seq_if
    import hex_mul_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned OP_W   = DIGIT_W * DIGITS;
    localparam int unsigned PROD_W = prod_width(DIGITS);

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/hex_pp_gen.sv
// Partial-product generator: multiplies digit i of a_op by digit j of b_op
// and returns the 8-bit result placed at bit 4*(i+j) of a full-width word.
//   a_op, b_op : captured operands
//   i, j       : digit indices
//   pp         : shifted partial product, product width
module hex_pp_gen
    import hex_mul_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [DIGIT_W*DIGITS-1:0]     a_op,
    input  logic [DIGIT_W*DIGITS-1:0]     b_op,
    input  logic [IDX_W-1:0]              i,
    input  logic [IDX_W-1:0]              j,
    output logic [prod_width(DIGITS)-1:0] pp
);
    localparam int unsigned PP_W   = 2 * DIGIT_W;
    localparam int unsigned PROD_W = prod_width(DIGITS);

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [PP_W-1:0]    pp8;

    // Digit select by right shift keeps the index fully variable.
    assign a_dig = DIGIT_W'(a_op >> (DIGIT_W * 32'(i)));
    assign b_dig = DIGIT_W'(b_op >> (DIGIT_W * 32'(j)));

    // Operands widened first so the 4x4 product keeps all 8 bits.
    assign pp8 = PP_W'(a_dig) * PP_W'(b_dig);

    // Widen before shifting: the top digit pair lands in the top byte.
    assign pp = PROD_W'(pp8) << (DIGIT_W * (32'(i) + 32'(j)));

endmodule

// File: rtl/hex_mul_seq.sv
// Digit-serial unsigned hex multiplier. One 4x4 partial product per cycle is
// accumulated over DIGITS^2 cycles, with valid/ready handshakes on both sides.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hex_mul_seq_if slave (in_valid/in_ready/a/b,
//              out_valid/out_ready/product, busy)
module hex_mul_seq
    import hex_mul_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    hex_mul_seq_if.slave bus
);
    localparam int unsigned OP_W   = DIGIT_W * DIGITS;
    localparam int unsigned PROD_W = prod_width(DIGITS);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    hex_mul_state_t    state;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [IDX_W-1:0]  i_q;
    logic [IDX_W-1:0]  j_q;
    logic [PROD_W-1:0] acc;
    logic              out_valid_q;
    logic [PROD_W-1:0] pp;

    hex_pp_gen #(
        .DIGITS (DIGITS),
        .IDX_W  (IDX_W)
    ) u_pp_gen (
        .a_op (a_q),
        .b_op (b_q),
        .i    (i_q),
        .j    (j_q),
        .pp   (pp)
    );

    // Sequencer: capture, DIGITS^2 accumulate steps, then hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        i_q   <= '0;
                        j_q   <= '0;
                        acc   <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc <= acc + pp;
                    if (j_q == LAST_IDX) begin
                        j_q <= '0;
                        if (i_q == LAST_IDX) begin
                            i_q         <= '0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                DONE: begin
                    // Product stays in acc until the next acceptance clears it.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Ready drops combinationally with rst so nothing is accepted during reset.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.product   = acc;

endmodule

// File: tb/tb_hex_mul_seq.sv
// Self-checking bench for hex_mul_seq at DIGITS = 4, 1 and 8.
module tb_hex_mul_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hex_mul_seq_if #(.DIGITS(4)) if4 ();
    hex_mul_seq_if #(.DIGITS(1)) if1 ();
    hex_mul_seq_if #(.DIGITS(8)) if8 ();

    hex_mul_seq #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    hex_mul_seq #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    hex_mul_seq #(.DIGITS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction on the DIGITS=4 instance with out_ready held high.
    task automatic op4(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        if4.a = a; if4.b = b; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        chk({tag, "_in_ready"}, 64'(if4.in_ready), 64'd1);
        @(negedge clk);
        // Operand changes after acceptance must not matter.
        if4.in_valid = 1'b0; if4.a = ~a; if4.b = ~b;
        cyc = 0;
        while (!if4.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd16);
        chk({tag, "_product"}, 64'(if4.product), 64'(exp));
        chk({tag, "_busy"}, 64'(if4.busy), 64'd1);
        @(negedge clk);
        chk({tag, "_ov_clear"}, 64'(if4.out_valid), 64'd0);
        chk({tag, "_idle_ready"}, 64'(if4.in_ready), 64'd1);
        chk({tag, "_prod_hold"}, 64'(if4.product), 64'(exp));
    endtask

    task automatic op1(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        if1.a = a; if1.b = b; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        cyc = 0;
        while (!if1.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd1);
        chk({tag, "_product"}, 64'(if1.product), 64'(exp));
        @(negedge clk);
        chk({tag, "_idle_ready"}, 64'(if1.in_ready), 64'd1);
    endtask

    task automatic op8(input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        logic [63:0] exp;
        exp = 64'(a) * 64'(b);
        @(negedge clk);
        if8.a = a; if8.b = b; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        cyc = 0;
        while (!if8.out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd64);
        chk({tag, "_product"}, if8.product, exp);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0000, 16'hABCD, 32'h0000_0000};
        vecs[3] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[4] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
        vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vecs[7] = '{16'hABCD, 16'h1234, 32'h0C37_4FA4};
        vecs[8] = '{16'h1000, 16'h1000, 32'h0100_0000};

        rst = 1'b1;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(if4.out_valid), 64'd0);
        chk("rst_product", 64'(if4.product), 64'd0);
        chk("rst_busy", 64'(if4.busy), 64'd0);
        chk("rst_in_ready", 64'(if4.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(if4.in_ready), 64'd1);

        // Directed table on DIGITS=4.
        for (int k = 0; k < 9; k++) begin
            op4(vecs[k].a, vecs[k].b, vecs[k].p, $sformatf("vec%0d", k));
        end

        // Backpressure: result held, extra operands refused.
        @(negedge clk);
        if4.a = 16'h0012; if4.b = 16'h0034; if4.in_valid = 1'b1; if4.out_ready = 1'b0;
        @(negedge clk);
        if4.in_valid = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!if4.out_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("bp_latency", 64'(cyc), 64'd16);
        end
        if4.a = 16'hFFFF; if4.b = 16'hFFFF; if4.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_ov%0d", k), 64'(if4.out_valid), 64'd1);
            chk($sformatf("bp_hold_prod%0d", k), 64'(if4.product), 64'h3A8);
            chk($sformatf("bp_hold_rdy%0d", k), 64'(if4.in_ready), 64'd0);
        end
        if4.in_valid = 1'b0; if4.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ov", 64'(if4.out_valid), 64'd0);
        chk("bp_release_rdy", 64'(if4.in_ready), 64'd1);
        chk("bp_release_prod", 64'(if4.product), 64'h3A8);
        chk("bp_release_busy", 64'(if4.busy), 64'd0);

        // Reset on compute step 7 discards the operation.
        @(negedge clk);
        if4.a = 16'hFFFF; if4.b = 16'hFFFF; if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", 64'(if4.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(if4.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(if4.out_valid), 64'd0);
        chk("mid_rst_prod", 64'(if4.product), 64'd0);
        chk("mid_rst_busy", 64'(if4.busy), 64'd0);
        chk("mid_rst_rdy", 64'(if4.in_ready), 64'd1);
        op4(16'h0003, 16'h0005, 32'h0000_000F, "post_rst");

        // DIGITS=1 corner.
        op1(4'hF, 4'hE, 8'hD2, "d1_fe");
        op1(4'h0, 4'h7, 8'h00, "d1_zero");

        // DIGITS=8 edges and random sweep against a*b.
        op8(32'hFFFF_FFFF, 32'hFFFF_FFFF, "d8_max");
        op8(32'h8000_0000, 32'h0000_0002, "d8_msb");
        for (int k = 0; k < 1000; k++) begin
            op8($urandom(), $urandom(), $sformatf("d8_rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
